alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Front-end controller for the combinational 16-bit ALU. It accepts operation requests over a valid/ready handshake, drives the ALU inputs from latched operands, and runs one pass (narrow) or two chained passes (wide, 2N-bit) through the ALU. It owns the architectural flag register {N,V,Z,C} and returns results over a valid/ready response channel. It sits between the instruction issue logic and the single ALU instance.

Parameters:
N, 16, ALU word width; wide ops are 2N bits.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept (high only in IDLE)
req_func  in  4  ALU function code
req_wide  in  1  1 = 2N-bit operation
req_a  in  2N  operand A (narrow uses [N-1:0])
req_b  in  2N  operand B (narrow uses [N-1:0])
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_y  out  2N  result
resp_err  out  1  request rejected
flags  out  4  flag register {N,V,Z,C}
alu_a, alu_b  out  N  ALU operands
alu_func  out  4  ALU function
alu_ci  out  1  ALU carry-in
alu_y, alu_out_to_a  in  N  ALU result / multiply high word
alu_co, alu_zero, alu_overflow, alu_negative  in  1  ALU status

Behaviour:
- Reset: state IDLE; req_ready=1 after reset; resp_valid=0, resp_err=0, resp_y=0, flags=0; alu_* outputs=0. Reset mid-operation drops the in-flight op, no response, flags cleared.
- States: IDLE, LO, HI, RESP.
- IDLE: req_ready=1. On req_valid, latch func/wide/a/b. If wide and func[3:2] is 01 or 10 (mul/asr/combine/shifts): go RESP, resp_err=1, resp_y=0, flags unchanged. Else go LO.
- LO: alu_a=a[N-1:0], alu_b=b[N-1:0], alu_func=func. alu_ci = flags.C for narrow func 0001/0011; 0 for wide or any other func. Narrow: capture resp_y={alu_out_to_a, alu_y} (upper half is 0 except mul), flags<= {alu_negative, alu_overflow, alu_zero, alu_co}, go RESP. Wide: capture lo word, lo_zero, lo_co; go HI.
- HI (wide only): alu_a=a[2N-1:N], alu_b=b[2N-1:N]. Arithmetic (00zz): alu_func={func[3:1],1'b1}, alu_ci=lo_co. Logic (11zz): alu_func=func, alu_ci=0. Capture resp_y={alu_y, lo}; flags<= {alu_negative, alu_overflow, alu_zero & lo_zero, arithmetic ? alu_co : 0}. Go RESP.
- RESP: resp_valid=1, resp_y/resp_err stable until resp_ready; on resp_valid&resp_ready go IDLE, clear resp_err. Flags written exactly once per op, at entry to RESP.
- alu_* outputs = 0 in IDLE and RESP.
- Latency from accept: narrow resp_valid 2 cycles later; wide 3; error 1. Max throughput one op per 3 (narrow) / 4 (wide) cycles with resp_ready=1. No overlap of request and response.

Test Plan:
- Narrow add 0x7FFF+0x0001 (func 0000) -> resp_y=0x00008000, flags N=1 V=1 Z=0 C=0, resp_valid 2 cycles after accept.
- Wide add 0x0000FFFF+0x00000001 -> LO co=1, HI func 0001 ci=1; resp_y=0x00010000, flags N=0 V=0 Z=0 C=0, resp_valid 3 cycles after accept.
- Wide sub 0x00030005-0x00010002 (func 0010) -> HI func 0011 ci=0; resp_y=0x00020003, C=0, Z=0; then narrow adc (0001) 1+1 with C=0 -> alu_ci=0, resp_y=0x00000002.
- Narrow mul 0xFFFE*0x0003 (func 0100) -> resp_y=0xFFFFFFFA, N=1, Z=0, V=0.
- Wide func 1000 -> resp_err=1 one cycle after accept, resp_y=0, flags unchanged; hold resp_ready=0 for 3 cycles -> resp_valid/resp_err held, req_ready=0, flags unchanged.
- Assert reset during HI of a wide add -> next cycle IDLE, req_ready=1, resp_valid=0, flags=0; next request completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the combinational ALU: runs one (narrow) or two chained (wide) passes,
// owns the {N,V,Z,C} flag register and returns results over a valid/ready channel.
module alu_op_sequencer #(
   parameter int unsigned N = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [3:0]     req_func,
   input  logic           req_wide,
   input  logic [2*N-1:0] req_a,
   input  logic [2*N-1:0] req_b,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [2*N-1:0] resp_y,
   output logic           resp_err,
   output logic [3:0]     flags,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   output logic [3:0]     alu_func,
   output logic           alu_ci,
   input  logic [N-1:0]   alu_y,
   input  logic [N-1:0]   alu_out_to_a,
   input  logic           alu_co,
   input  logic           alu_zero,
   input  logic           alu_overflow,
   input  logic           alu_negative
);

   typedef enum logic [1:0] {st_idle, st_lo, st_hi, st_resp} state_t;

   state_t         state;
   logic [3:0]     op_func;
   logic           op_wide;
   logic [2*N-1:0] op_a;
   logic [2*N-1:0] op_b;
   logic [N-1:0]   lo_y;
   logic           lo_zero;
   logic           op_arith;
   logic           req_bad;

   assign op_arith = (op_func[3:2] == 2'b00);
   // Wide mul/shift/combine cannot be chained across halves.
   assign req_bad  = req_wide && ((req_func[3:2] == 2'b01) || (req_func[3:2] == 2'b10));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= st_idle;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_y     <= '0;
         flags      <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_func   <= '0;
         alu_ci     <= 1'b0;
         op_func    <= '0;
         op_wide    <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         lo_y       <= '0;
         lo_zero    <= 1'b0;
      end else begin
         case (state)
            st_idle: begin
               if (req_valid) begin
                  op_func   <= req_func;
                  op_wide   <= req_wide;
                  op_a      <= req_a;
                  op_b      <= req_b;
                  req_ready <= 1'b0;
                  if (req_bad) begin
                     state      <= st_resp;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_y     <= '0;
                  end else begin
                     // ALU inputs are registered, so the LO pass is set up here.
                     state    <= st_lo;
                     alu_a    <= req_a[N-1:0];
                     alu_b    <= req_b[N-1:0];
                     alu_func <= req_func;
                     alu_ci   <= !req_wide && ((req_func == 4'b0001) || (req_func == 4'b0011))
                                 ? flags[0] : 1'b0;
                  end
               end
            end
            st_lo: begin
               if (op_wide) begin
                  state    <= st_hi;
                  lo_y     <= alu_y;
                  lo_zero  <= alu_zero;
                  alu_a    <= op_a[2*N-1:N];
                  alu_b    <= op_b[2*N-1:N];
                  alu_func <= op_arith ? {op_func[3:1], 1'b1} : op_func;
                  alu_ci   <= op_arith ? alu_co : 1'b0;
               end else begin
                  state      <= st_resp;
                  resp_valid <= 1'b1;
                  resp_y     <= {(op_func == 4'b0100) ? alu_out_to_a : {N{1'b0}}, alu_y};
                  flags      <= {alu_negative, alu_overflow, alu_zero, alu_co};
                  alu_a      <= '0;
                  alu_b      <= '0;
                  alu_func   <= '0;
                  alu_ci     <= 1'b0;
               end
            end
            st_hi: begin
               state      <= st_resp;
               resp_valid <= 1'b1;
               resp_y     <= {alu_y, lo_y};
               flags      <= {alu_negative, alu_overflow, alu_zero & lo_zero,
                              op_arith ? alu_co : 1'b0};
               alu_a      <= '0;
               alu_b      <= '0;
               alu_func   <= '0;
               alu_ci     <= 1'b0;
            end
            st_resp: begin
               if (resp_ready) begin
                  state      <= st_idle;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= st_idle;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
